// File: rtl/sail_alu_pipe.sv
// sail_alu_pipe: elastic pipelined ALU for the sail execute stage.
// Operands are forwarded and the result is computed at accept, then captured
// into stage 1 and delayed through LATENCY-1 further stages. A single global
// stall holds every stage while the output is valid but not consumed.
module sail_alu_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             mem_fwd_a,
  input  logic             wb_fwd_a,
  input  logic             mem_fwd_b,
  input  logic             wb_fwd_b,
  input  logic             flush,
  output logic             branch_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned ShW = $clog2(WIDTH);

  // ALUctl[3:0] operation codes
  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSrl   = 4'b0011;
  localparam logic [3:0] OpSra   = 4'b0100;
  localparam logic [3:0] OpSll   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpXor   = 4'b1000;
  localparam logic [3:0] OpCsrrw = 4'b1001;
  localparam logic [3:0] OpCsrrs = 4'b1010;
  localparam logic [3:0] OpCsrrc = 4'b1011;

  // ALUctl[6:4] branch condition codes
  localparam logic [2:0] BrBeq  = 3'b001;
  localparam logic [2:0] BrBne  = 3'b010;
  localparam logic [2:0] BrBlt  = 3'b011;
  localparam logic [2:0] BrBge  = 3'b100;
  localparam logic [2:0] BrBltu = 3'b101;
  localparam logic [2:0] BrBgeu = 3'b110;

  logic [WIDTH-1:0] a_f;
  logic [WIDTH-1:0] b_f;
  logic [ShW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sra;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             cond;
  logic             stall;
  logic             accept;

  logic [LATENCY-1:0]            valid_q;
  logic [LATENCY-1:0][WIDTH-1:0] res_q;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q;
  logic [LATENCY-1:0]            zero_q;
  logic [LATENCY-1:0]            carry_q;

  // Operand forwarding; MEM is newer than WB so it wins.
  always_comb begin
    a_f = a;
    if (mem_fwd_a)     a_f = mem_result;
    else if (wb_fwd_a) a_f = wb_result;
    b_f = b;
    if (mem_fwd_b)     b_f = mem_result;
    else if (wb_fwd_b) b_f = wb_result;
  end

  assign shamt = b_f[ShW-1:0];
  assign sum   = {1'b0, a_f} + {1'b0, b_f};
  assign diff  = {1'b0, a_f} + {1'b0, ~b_f} + (WIDTH+1)'(1);
  assign sra   = $signed(a_f) >>> shamt;
  assign eq    = (a_f == b_f);
  assign lt_s  = ($signed(a_f) < $signed(b_f));
  assign lt_u  = (a_f < b_f);

  // Operation decode; unlisted codes give zero with no carry.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (alu_ctl[3:0])
      OpAnd:   res_d = a_f & b_f;
      OpOr:    res_d = a_f | b_f;
      OpXor:   res_d = a_f ^ b_f;
      OpAdd:   begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      OpSub:   begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
      end
      OpSlt:   res_d = {{(WIDTH-1){1'b0}}, lt_s};
      OpSll:   res_d = a_f << shamt;
      OpSrl:   res_d = a_f >> shamt;
      OpSra:   res_d = sra;
      OpCsrrw: res_d = a_f;
      OpCsrrs: res_d = a_f | b_f;
      OpCsrrc: res_d = ~a_f & b_f;
      default: ;
    endcase
  end

  // Branch condition, evaluated combinationally at issue.
  always_comb begin
    cond = 1'b0;
    case (alu_ctl[6:4])
      BrBeq:   cond = eq;
      BrBne:   cond = ~eq;
      BrBlt:   cond = lt_s;
      BrBge:   cond = ~lt_s;
      BrBltu:  cond = lt_u;
      BrBgeu:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign branch_enable = in_valid & cond;

  // Global stall: every stage holds while the head result waits for the consumer.
  assign stall    = valid_q[LATENCY-1] & ~out_ready;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;

  // Valid bits: flush clears everything (even under stall), else shift when not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload registers: result, tag and flags move with the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      tag_q   <= '0;
      zero_q  <= '0;
      carry_q <= '0;
    end else if (!stall) begin
      res_q[0]   <= res_d;
      tag_q[0]   <= tag;
      zero_q[0]  <= (res_d == '0);
      carry_q[0] <= carry_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        res_q[i]   <= res_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        zero_q[i]  <= zero_q[i-1];
        carry_q[i] <= carry_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign result    = res_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign zero      = zero_q[LATENCY-1];
  assign carry     = carry_q[LATENCY-1];

endmodule

// File: doc/sail_alu_pipe.md
# sail_alu_pipe

Parametrised, elastic pipelined ALU for the sail core execute stage. It generalises the fixed two-stage ALU in three ways: configurable data width and pipeline depth, a valid/ready handshake with backpressure and flush, and a tag plus flag sideband. The block accepts forwarded operands from MEM/WB, performs the `ALUctl[3:0]` operation from `sail-core-defines.v`, and evaluates the `ALUctl[6:4]` branch condition combinationally at issue.

## Interface
- `WIDTH`, 32: datapath width; power of two, 8..64.
- `LATENCY`, 2: register stages from accept to output, 1..4.
- `TAG_W`, 5: width of the opaque tag carried with each op (e.g. rd index).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  op present on the inputs.
- `in_ready`  out  1  block can accept the op this cycle.
- `alu_ctl`  in  7  ALUctl encoding; `[3:0]` selects the op, `[6:4]` selects the branch condition.
- `a`, `b`  in  WIDTH  register-file operands.
- `tag`  in  TAG_W  sideband; returned unchanged with the result.
- `mem_result`, `wb_result`  in  WIDTH  forwarding sources.
- `mem_fwd_a`, `wb_fwd_a`, `mem_fwd_b`, `wb_fwd_b`  in  1  forwarding selects.
- `flush`  in  1  kill all in-flight ops.
- `branch_enable`  out  1  branch condition result, combinational.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  ALU result.
- `out_tag`  out  TAG_W  tag of the result.
- `zero`  out  1  `result == 0`.
- `carry`  out  1  carry-out of ADD, or NOT borrow of SUB; 0 for all other ops.

## Operation
- **Operand forwarding:**
  - `a_f = mem_fwd_a ? mem_result : wb_fwd_a ? wb_result : a`.
  - `b_f` is formed the same way from `mem_fwd_b`, `wb_fwd_b` and `b`.
  - MEM has priority over WB.
- **Compute:**
  - The result is computed from `a_f`/`b_f` at accept and captured into stage 1 together with the op's valid bit, tag and flags.
  - Stages 2..LATENCY are pure delay registers.
- **Operations:**
  - AND, OR, XOR.
  - ADD is the WIDTH+1-bit sum; `carry` is the MSB.
  - SUB is `a_f + ~b_f + 1`; `carry` is the carry-out.
  - SLT is a signed compare giving 1 or 0.
  - SLL, SRL and SRA use the shift amount `b_f[$clog2(WIDTH)-1:0]`.
  - CSRRW gives `a_f`; CSRRS gives `a_f | b_f`; CSRRC gives `~a_f & b_f`.
  - Any other code gives 0 with `carry` 0.
- **Branch condition:**
  - BEQ, BNE, BLT, BGE, BLTU and BGEU compare `a_f` with `b_f`.
  - The output is `in_valid & cond`; it is 0 for other `[6:4]` codes.
- **Handshake (global stall):**
  - `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall`.
  - Accept happens when `in_valid & in_ready`.
  - When not stalled, every stage shifts forward by one; a stage with no new op loads valid=0.
  - When stalled, all stages hold.
  - Bubbles are not squeezed.
- **Flush:**
  - Synchronous; all stage valid bits are cleared at the edge.
  - An op offered in the same cycle is not accepted; `in_ready` is 0 while `flush` is high.
  - Flush overrides stall.
  - Data and tag registers may retain stale values; only the valid bits are defined.
- **Reset:**
  - All valid bits, `result`, `out_tag`, `zero` and `carry` are 0.
  - `in_ready` is 1 once `flush` is low; `branch_enable` follows its inputs.
  - Reset asserted mid-operation discards all in-flight ops with no output.

## Timing
- Accept at edge N: `out_valid` and the result appear after edge N+LATENCY−1 if no stall occurs (LATENCY=1: output directly after the accept edge).
- Each stall cycle adds one cycle to every op in flight.
- Throughput is one op per cycle while `out_ready` is held high.
- `out_valid`/`result`/`out_tag`/flags are held stable until the cycle in which `out_valid & out_ready`.
- `in_ready` depends combinationally on `out_ready`. This is the only in→out combinational path besides `branch_enable`, which depends on `in_valid`, `alu_ctl`, the operand, forwarding and select inputs.
- Ordering: results leave in acceptance order, with no reordering.

## Test plan
- WIDTH=32, LATENCY=2, `out_ready`=1:
  - ADD `a=0xFFFF_FFFF`, `b=1` → result 0, `zero`=1, `carry`=1, `out_valid` one cycle after the accept edge.
  - SUB `5-7` → `0xFFFF_FFFE`, `carry`=0.
- Forwarding: all four selects high, `mem_result=3`, `wb_result=9`, `a=b=100`, op SUB → result 0 (MEM wins); BEQ `branch_enable`=1 combinationally in the same cycle.
- Shifts: SRA `a=0x8000_0000`, `b=0x24` (amount 4) → `0xF800_0000`; SLL `a=1`, `b=31` → `0x8000_0000`; WIDTH=16 build, SRL `0x8000>>15` → 1.
- Backpressure: issue ops with tags 1..4 back-to-back, drop `out_ready` for 3 cycles after tag 1 appears → `in_ready`=0 during the stall; tag 1 held stable; tags 1..4 emerge in order, with no loss and no duplication.
- Flush: with 2 ops in flight, assert `flush` together with a new `in_valid` → `out_valid` stays 0 for the next LATENCY cycles; an op issued the following cycle appears normally.
- Reset mid-stream: assert `rst` asynchronously between edges with the pipeline full → all outputs 0 immediately; no stale result after deassertion. Repeat the bench for LATENCY=1 and LATENCY=4.
